// File: rtl/dmem_write_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_write_arbiter
//
// Shares the single write port of a 16x8 data memory between two requesters
// (port 0: core store path, port 1: loader/debug path) with round-robin
// arbitration. A clear sequencer zeroes all 16 locations on command and has
// priority over both requesters. All mem_write_* outputs are registered, so
// there is no combinational path from req_* to the memory.
//
// Handshake: a write on port i transfers on a rising clk edge where
// req_valid[i] and req_ready[i] are both high. req_ready is combinational,
// at most one bit is ever high, and a requester must hold valid/addr/data
// stable until it sees ready.
//
// Ports:
//   clk              in   1  clock, rising edge
//   reset            in   1  asynchronous, active-low reset
//   req_valid        in   2  per-port write request (bit i = port i)
//   req_addr_0/1     in   4  write address per port
//   req_data_0/1     in   8  write data per port
//   req_ready        out  2  per-port accept
//   clear_start      in   1  single-cycle pulse starting a full clear
//   clear_busy       out  1  high while the clear sequencer owns the port
//   clear_done       out  1  one-cycle pulse with the last clear write
//   mem_write_enable out  1  registered memory write enable
//   mem_write_addr   out  4  registered memory write address
//   mem_write_data   out  8  registered memory write data
//   dbg_state        out  1  FSM state (0 = IDLE, 1 = CLEAR)
// -----------------------------------------------------------------------------
module dmem_write_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_valid,
   input  logic [3:0] req_addr_0,
   input  logic [3:0] req_addr_1,
   input  logic [7:0] req_data_0,
   input  logic [7:0] req_data_1,
   output logic [1:0] req_ready,
   input  logic       clear_start,
   output logic       clear_busy,
   output logic       clear_done,
   output logic       mem_write_enable,
   output logic [3:0] mem_write_addr,
   output logic [7:0] mem_write_data,
   output logic       dbg_state
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_clr_cnt;
   logic       r_prio;
   logic       r_we;
   logic [3:0] r_addr;
   logic [7:0] r_data;
   logic       r_done;

   logic [1:0] w_ready;
   logic       w_accept;
   logic       w_grant;
   logic       w_clear_go;
   logic       w_clear_last;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; clear_start while already clearing is ignored
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (clear_start)  w_state_next = ST_CLEAR;
         ST_CLEAR: if (w_clear_last) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   assign w_clear_go   = (r_state == ST_IDLE) && clear_start;
   assign w_clear_last = (r_state == ST_CLEAR) && (r_clr_cnt == 4'd15);

   // Output logic. Ready is withheld during reset, while clearing, and in
   // the cycle a clear is being started, so pending requests simply wait.
   always_comb begin
      w_ready = 2'b00;
      if (reset && (r_state == ST_IDLE) && !clear_start) begin
         if (req_valid == 2'b11) begin
            w_ready = r_prio ? 2'b10 : 2'b01;
         end else begin
            w_ready = req_valid;
         end
      end
   end

   assign req_ready  = w_ready;
   assign clear_busy = (r_state == ST_CLEAR);
   assign dbg_state  = r_state;

   // w_ready is one-hot or zero, so bit 1 alone identifies the granted port
   assign w_accept = |(req_valid & w_ready);
   assign w_grant  = w_ready[1];

   // Write-port datapath, clear counter and round-robin pointer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clr_cnt <= 4'd0;
         r_prio    <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= 4'd0;
         r_data    <= 8'd0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_clear_go) begin
            // Address 0 goes out on the start edge; counter tracks the next one
            r_we      <= 1'b1;
            r_addr    <= 4'd0;
            r_data    <= 8'd0;
            r_clr_cnt <= 4'd1;
         end else if (r_state == ST_CLEAR) begin
            r_we      <= 1'b1;
            r_addr    <= r_clr_cnt;
            r_data    <= 8'd0;
            r_clr_cnt <= r_clr_cnt + 4'd1;
            r_done    <= w_clear_last;
         end else if (w_accept) begin
            r_we   <= 1'b1;
            r_addr <= w_grant ? req_addr_1 : req_addr_0;
            r_data <= w_grant ? req_data_1 : req_data_0;
            r_prio <= ~w_grant;
         end else begin
            r_we <= 1'b0;
         end
      end
   end

   assign mem_write_enable = r_we;
   assign mem_write_addr   = r_addr;
   assign mem_write_data   = r_data;
   assign clear_done       = r_done;

endmodule

// File: tb/tb_dmem_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_write_arbiter
//
// Directed bench for dmem_write_arbiter. Stimulus pushes each expected memory
// write {addr, data} into exp_q; a monitor pops and compares whenever the DUT
// presents mem_write_enable. Handshake and control outputs are checked
// directly by the stimulus process against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dmem_write_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [3:0] req_addr_0 = 4'd0;
   logic [3:0] req_addr_1 = 4'd0;
   logic [7:0] req_data_0 = 8'd0;
   logic [7:0] req_data_1 = 8'd0;
   logic [1:0] req_ready;
   logic       clear_start = 1'b0;
   logic       clear_busy;
   logic       clear_done;
   logic       mem_write_enable;
   logic [3:0] mem_write_addr;
   logic [7:0] mem_write_data;
   logic       dbg_state;

   logic [11:0] exp_q[$];
   int n_pass = 0;
   int n_total = 0;
   int done_cnt;

   dmem_write_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_addr_0       (req_addr_0),
      .req_addr_1       (req_addr_1),
      .req_data_0       (req_data_0),
      .req_data_1       (req_data_1),
      .req_ready        (req_ready),
      .clear_start      (clear_start),
      .clear_busy       (clear_busy),
      .clear_done       (clear_done),
      .mem_write_enable (mem_write_enable),
      .mem_write_addr   (mem_write_addr),
      .mem_write_data   (mem_write_data),
      .dbg_state        (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (mem_write_enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                     mem_write_addr, mem_write_data);
         end else begin
            check("mem_write", {20'd0, mem_write_addr, mem_write_data}, {20'd0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_clear(input int last);
      for (int a = 0; a <= last; a++) exp_q.push_back({a[3:0], 8'h00});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset held with inputs toggling
      #2 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_valid   = i[1:0] ^ 2'b11;
         clear_start = i[0];
         req_addr_0  = 4'(i + 3);
         req_data_0  = 8'(8'h30 + i);
         @(negedge clk);
         check("rst_ready", {30'd0, req_ready}, 32'd0);
         check("rst_we",    {31'd0, mem_write_enable}, 32'd0);
         check("rst_addr",  {28'd0, mem_write_addr}, 32'd0);
         check("rst_data",  {24'd0, mem_write_data}, 32'd0);
         check("rst_done",  {31'd0, clear_done}, 32'd0);
         check("rst_busy",  {31'd0, clear_busy}, 32'd0);
         tick();
      end

      // Release; single write on port 0
      reset = 1'b1;
      clear_start = 1'b0;
      req_valid = 2'b01; req_addr_0 = 4'd3; req_data_0 = 8'hA5;
      @(negedge clk);
      check("p0_ready", {30'd0, req_ready}, 32'd1);
      exp_q.push_back({4'd3, 8'hA5});
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      check("p0_we", {31'd0, mem_write_enable}, 32'd1);
      tick();
      @(negedge clk);
      check("idle_we", {31'd0, mem_write_enable}, 32'd0);
      tick();

      // Port 1 alone writes once (pointer now favours port 0)
      req_valid = 2'b10; req_addr_1 = 4'd5; req_data_1 = 8'h55;
      @(negedge clk);
      check("p1_ready", {30'd0, req_ready}, 32'd2);
      exp_q.push_back({4'd5, 8'h55});
      tick();

      // Contention: both valid for 4 cycles, expect 0,1,0,1
      req_valid = 2'b11;
      req_addr_0 = 4'd1; req_data_0 = 8'h11;
      req_addr_1 = 4'd2; req_data_1 = 8'h22;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("cont_ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
         if (i % 2 == 0) exp_q.push_back({4'd1, 8'h11});
         else            exp_q.push_back({4'd2, 8'h22});
         tick();
      end
      req_valid = 2'b00;
      @(negedge clk);
      tick();

      // Clear with port 0 pending
      req_valid = 2'b01; req_addr_0 = 4'd4; req_data_0 = 8'h44;
      clear_start = 1'b1;
      @(negedge clk);
      check("clr_start_ready", {30'd0, req_ready}, 32'd0);
      push_clear(15);
      tick();
      clear_start = 1'b0;
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         check("clr_ready", {30'd0, req_ready}, 32'd0);
         check("clr_done_low", {31'd0, clear_done}, 32'd0);
         if (j >= 1) check("clr_busy", {31'd0, clear_busy}, 32'd1);
         tick();
      end
      @(negedge clk);
      check("clr_done", {31'd0, clear_done}, 32'd1);
      check("clr_done_addr", {28'd0, mem_write_addr}, 32'd15);
      check("clr_end_busy", {31'd0, clear_busy}, 32'd0);
      check("post_clr_ready", {30'd0, req_ready}, 32'd1);
      exp_q.push_back({4'd4, 8'h44});
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      check("done_pulse_end", {31'd0, clear_done}, 32'd0);
      tick();

      // Clear re-trigger at address 7
      clear_start = 1'b1;
      push_clear(15);
      tick();
      done_cnt = 0;
      for (int j = 0; j < 15; j++) begin
         clear_start = (j == 7);
         @(negedge clk);
         done_cnt += int'(clear_done);
         if (j >= 1) check("retrig_busy", {31'd0, clear_busy}, 32'd1);
         tick();
      end
      clear_start = 1'b0;
      @(negedge clk);
      done_cnt += int'(clear_done);
      check("retrig_done", {31'd0, clear_done}, 32'd1);
      check("retrig_addr", {28'd0, mem_write_addr}, 32'd15);
      tick();
      @(negedge clk);
      done_cnt += int'(clear_done);
      check("retrig_done_count", done_cnt, 32'd1);
      check("retrig_idle_busy", {31'd0, clear_busy}, 32'd0);
      check("retrig_idle_we", {31'd0, mem_write_enable}, 32'd0);
      tick();

      // Reset mid-clear at address 9
      clear_start = 1'b1;
      push_clear(9);
      tick();
      clear_start = 1'b0;
      for (int j = 0; j <= 9; j++) begin
         @(negedge clk);
         if (j < 9) tick();
      end
      check("pre_rst_addr", {28'd0, mem_write_addr}, 32'd9);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_we",   {31'd0, mem_write_enable}, 32'd0);
      check("mid_rst_addr", {28'd0, mem_write_addr}, 32'd0);
      check("mid_rst_data", {24'd0, mem_write_data}, 32'd0);
      check("mid_rst_busy", {31'd0, clear_busy}, 32'd0);
      check("mid_rst_done", {31'd0, clear_done}, 32'd0);
      check("mid_rst_ready", {30'd0, req_ready}, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (j == 10) check("post_rst_we", {31'd0, mem_write_enable}, 32'd0);
         if (j == 10) check("post_rst_busy", {31'd0, clear_busy}, 32'd0);
         tick();
      end

      check("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
